// File: rtl/stopwatch_uart_pkg.sv
// Shared constants and types for the stopwatch-to-UART message path:
// ASCII codes, the transmit FSM state encoding and the message layout.
package stopwatch_uart_pkg;

  // ASCII codes used when building the "MM:SS.T" text line
  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;

  // Message lengths for the two terminator flavours
  localparam int MSG_LEN_CRLF = 9;
  localparam int MSG_LEN_LF   = 8;

  // Width of the byte index register
  localparam int IDX_W = 4;

  // Byte positions within a message
  localparam logic [IDX_W-1:0] POS_MIN_TENS = 4'd0;
  localparam logic [IDX_W-1:0] POS_MIN_ONES = 4'd1;
  localparam logic [IDX_W-1:0] POS_COLON    = 4'd2;
  localparam logic [IDX_W-1:0] POS_SEC_TENS = 4'd3;
  localparam logic [IDX_W-1:0] POS_SEC_ONES = 4'd4;
  localparam logic [IDX_W-1:0] POS_DOT      = 4'd5;
  localparam logic [IDX_W-1:0] POS_TENTHS   = 4'd6;
  localparam logic [IDX_W-1:0] POS_TERM0    = 4'd7;
  localparam logic [IDX_W-1:0] POS_TERM1    = 4'd8;

  // Transmit sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  // Index of the final byte of a message for a given terminator choice
  function automatic logic [IDX_W-1:0] last_index(input bit crlf);
    return crlf ? IDX_W'(MSG_LEN_CRLF - 1) : IDX_W'(MSG_LEN_LF - 1);
  endfunction

endpackage

// File: rtl/stopwatch_msg_tx_bcd_to_ascii.sv
// Converts one BCD digit to its printable ASCII character; any
// non-decimal nibble is shown as '?' so corrupt time values are visible.
module bcd_to_ascii
  import stopwatch_uart_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] ascii
);

  // Decimal digits map onto '0'..'9', everything else onto '?'
  always_comb begin
    if (bcd <= 4'd9) begin
      ascii = ASCII_ZERO + {4'd0, bcd};
    end else begin
      ascii = ASCII_QMARK;
    end
  end

endmodule

// File: rtl/stopwatch_msg_tx.sv
// Sends the captured stopwatch time to a byte-wide UART transmitter as
// the text line "MM:SS.T" plus CR LF (CRLF=1) or LF (CRLF=0). One byte is
// handed over per start strobe; the next byte waits for the transmitter's
// done tick. All outputs come straight from flops.
module stopwatch_msg_tx
  import stopwatch_uart_pkg::*;
#(
  parameter bit CRLF = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        send,
  input  logic [19:0] time_bcd,
  input  logic        tx_done_tick,
  output logic        tx_start_n,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        msg_done
);

  localparam logic [IDX_W-1:0] LAST_IDX = last_index(CRLF);

  state_t           state;
  state_t           state_nx;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nx;
  logic [19:0]      snap;
  logic [19:0]      snap_nx;

  logic [3:0]       digit_sel;
  logic [7:0]       digit_ascii;
  logic [7:0]       byte_nx;

  logic             tx_start_n_nx;
  logic [7:0]       tx_data_nx;
  logic             busy_nx;
  logic             msg_done_nx;

  // State, index, snapshot and the registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      snap       <= '0;
      tx_start_n <= 1'b1;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      msg_done   <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      snap       <= snap_nx;
      tx_start_n <= tx_start_n_nx;
      tx_data    <= tx_data_nx;
      busy       <= busy_nx;
      msg_done   <= msg_done_nx;
    end
  end

  // Sequencing: accept a request only when idle, then strobe/wait per byte
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    snap_nx  = snap;
    unique case (state)
      ST_IDLE: begin
        if (send) begin
          state_nx = ST_START;
          idx_nx   = '0;
          snap_nx  = time_bcd;
        end
      end
      ST_START: begin
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (tx_done_tick) begin
          if (idx == LAST_IDX) begin
            state_nx = ST_IDLE;
          end else begin
            idx_nx   = idx + 4'd1;
            state_nx = ST_START;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Pick the time digit that belongs to the byte about to be sent
  always_comb begin
    digit_sel = '0;
    case (idx_nx)
      POS_MIN_TENS: digit_sel = snap_nx[19:16];
      POS_MIN_ONES: digit_sel = snap_nx[15:12];
      POS_SEC_TENS: digit_sel = snap_nx[11:8];
      POS_SEC_ONES: digit_sel = snap_nx[7:4];
      POS_TENTHS:   digit_sel = snap_nx[3:0];
      default:      digit_sel = '0;
    endcase
  end

  bcd_to_ascii u_bcd_to_ascii (
    .bcd   (digit_sel),
    .ascii (digit_ascii)
  );

  // Assemble the byte for the upcoming position: digit, separator or terminator
  always_comb begin
    byte_nx = ASCII_LF;
    case (idx_nx)
      POS_MIN_TENS, POS_MIN_ONES, POS_SEC_TENS,
      POS_SEC_ONES, POS_TENTHS:  byte_nx = digit_ascii;
      POS_COLON:                 byte_nx = ASCII_COLON;
      POS_DOT:                   byte_nx = ASCII_DOT;
      POS_TERM0:                 byte_nx = CRLF ? ASCII_CR : ASCII_LF;
      POS_TERM1:                 byte_nx = ASCII_LF;
      default:                   byte_nx = ASCII_LF;
    endcase
  end

  // Next values of the registered outputs, derived from the next state
  always_comb begin
    tx_start_n_nx = (state_nx != ST_START);
    busy_nx       = (state_nx != ST_IDLE);
    msg_done_nx   = (state == ST_WAIT) && (state_nx == ST_IDLE);
    tx_data_nx    = (state_nx == ST_START) ? byte_nx : tx_data;
  end

endmodule

// File: tb/tb_stopwatch_msg_tx.sv
// Self-checking bench for stopwatch_msg_tx. Two instances (CR LF and LF-only)
// share all inputs; a transaction-level model predicts each one's outputs.
module tb_stopwatch_msg_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        send;
  logic [19:0] time_bcd;
  logic        tx_done_tick;

  logic        start_n_c, busy_c, done_c;
  logic [7:0]  data_c;
  logic        start_n_l, busy_l, done_l;
  logic [7:0]  data_l;

  int errors = 0;
  int checks = 0;

  // Model state per instance: 0 = CR LF instance, 1 = LF-only instance
  bit         m_busy  [2];
  bit         m_start [2];
  bit         m_done  [2];
  logic [7:0] m_data  [2];
  logic [7:0] m_bytes [2][9];
  int         m_pos   [2];
  int         m_len   [2];

  // Bytes seen on each start strobe and msg_done pulse counts
  logic [7:0] log_c [$];
  logic [7:0] log_l [$];
  int         done_cnt [2];

  logic [7:0] exp_a_c [9] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h2E, 8'h35, 8'h0D, 8'h0A};
  logic [7:0] exp_a_l [9] = '{8'h31, 8'h32, 8'h3A, 8'h33, 8'h34, 8'h2E, 8'h35, 8'h0A, 8'h00};
  logic [7:0] exp_z_c [9] = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h0D, 8'h0A};
  logic [7:0] exp_z_l [9] = '{8'h30, 8'h30, 8'h3A, 8'h30, 8'h30, 8'h2E, 8'h30, 8'h0A, 8'h00};
  logic [7:0] exp_q_c [9] = '{8'h31, 8'h32, 8'h3A, 8'h3F, 8'h34, 8'h2E, 8'h35, 8'h0D, 8'h0A};
  logic [7:0] exp_q_l [9] = '{8'h31, 8'h32, 8'h3A, 8'h3F, 8'h34, 8'h2E, 8'h35, 8'h0A, 8'h00};
  logic [7:0] exp_d_c [9] = '{8'h32, 8'h34, 8'h3A, 8'h36, 8'h38, 8'h2E, 8'h30, 8'h0D, 8'h0A};
  logic [7:0] exp_d_l [9] = '{8'h32, 8'h34, 8'h3A, 8'h36, 8'h38, 8'h2E, 8'h30, 8'h0A, 8'h00};
  logic [7:0] exp_r_c [9] = '{8'h35, 8'h34, 8'h3A, 8'h33, 8'h32, 8'h2E, 8'h31, 8'h0D, 8'h0A};
  logic [7:0] exp_r_l [9] = '{8'h35, 8'h34, 8'h3A, 8'h33, 8'h32, 8'h2E, 8'h31, 8'h0A, 8'h00};

  stopwatch_msg_tx #(.CRLF(1'b1)) dut_crlf (
    .clk          (clk),
    .rst_n        (rst_n),
    .send         (send),
    .time_bcd     (time_bcd),
    .tx_done_tick (tx_done_tick),
    .tx_start_n   (start_n_c),
    .tx_data      (data_c),
    .busy         (busy_c),
    .msg_done     (done_c)
  );

  stopwatch_msg_tx #(.CRLF(1'b0)) dut_lf (
    .clk          (clk),
    .rst_n        (rst_n),
    .send         (send),
    .time_bcd     (time_bcd),
    .tx_done_tick (tx_done_tick),
    .tx_start_n   (start_n_l),
    .tx_data      (data_l),
    .busy         (busy_l),
    .msg_done     (done_l)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Generic comparison with failure report
  task automatic checkOutput(input string name, input int inst,
                             input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s (inst %0d): actual=%0h required=%0h", name, inst, actual, expected);
    end
  endtask

  // Printable form of one BCD digit
  function automatic logic [7:0] ascii_of(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : 8'(8'h30 + 8'(d));
  endfunction

  // Text line the given instance must send for a captured time value
  task automatic build_msg(input int k, input logic [19:0] bcd);
    m_bytes[k][0] = ascii_of(bcd[19:16]);
    m_bytes[k][1] = ascii_of(bcd[15:12]);
    m_bytes[k][2] = 8'h3A;
    m_bytes[k][3] = ascii_of(bcd[11:8]);
    m_bytes[k][4] = ascii_of(bcd[7:4]);
    m_bytes[k][5] = 8'h2E;
    m_bytes[k][6] = ascii_of(bcd[3:0]);
    if (k == 0) begin
      m_bytes[k][7] = 8'h0D;
      m_bytes[k][8] = 8'h0A;
      m_len[k]      = 9;
    end else begin
      m_bytes[k][7] = 8'h0A;
      m_bytes[k][8] = 8'h00;
      m_len[k]      = 8;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k]  = 1'b0;
      m_start[k] = 1'b0;
      m_done[k]  = 1'b0;
      m_data[k]  = 8'h00;
      m_pos[k]   = 0;
    end
  endtask

  // Reference model: predicts outputs for the cycle following each edge
  initial begin
    bit was_start;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        for (int k = 0; k < 2; k++) begin
          was_start  = m_start[k];
          m_start[k] = 1'b0;
          m_done[k]  = 1'b0;
          if (!m_busy[k]) begin
            if (send) begin
              build_msg(k, time_bcd);
              m_pos[k]   = 0;
              m_busy[k]  = 1'b1;
              m_start[k] = 1'b1;
              m_data[k]  = m_bytes[k][0];
            end
          end else if (!was_start && tx_done_tick) begin
            if (m_pos[k] == m_len[k] - 1) begin
              m_busy[k] = 1'b0;
              m_done[k] = 1'b1;
            end else begin
              m_pos[k]   = m_pos[k] + 1;
              m_start[k] = 1'b1;
              m_data[k]  = m_bytes[k][m_pos[k]];
            end
          end
        end
      end
    end
  end

  // Per-cycle compare of both instances against the model, plus logging
  initial begin
    logic       act_s, act_b, act_m;
    logic [7:0] act_d;
    forever begin
      @(negedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
        act_s = (k == 0) ? start_n_c : start_n_l;
        act_b = (k == 0) ? busy_c    : busy_l;
        act_m = (k == 0) ? done_c    : done_l;
        act_d = (k == 0) ? data_c    : data_l;
        checkOutput("tx_start_n", k, 32'(act_s), 32'(!m_start[k]));
        checkOutput("busy",       k, 32'(act_b), 32'(m_busy[k]));
        checkOutput("msg_done",   k, 32'(act_m), 32'(m_done[k]));
        if (m_busy[k]) checkOutput("tx_data", k, 32'(act_d), 32'(m_data[k]));
        if (act_s === 1'b0) begin
          if (k == 0) log_c.push_back(act_d);
          else        log_l.push_back(act_d);
        end
        if (act_m === 1'b1) done_cnt[k]++;
      end
    end
  end

  task automatic clear_logs();
    log_c.delete();
    log_l.delete();
    done_cnt[0] = 0;
    done_cnt[1] = 0;
  endtask

  // Compare the bytes logged for one instance against a literal message
  task automatic checkLog(input string name, input int k,
                          input logic [7:0] exp [9], input int len);
    int         n;
    logic [7:0] got;
    n = (k == 0) ? log_c.size() : log_l.size();
    checkOutput({name, "_len"}, k, 32'(n), 32'(len));
    for (int i = 0; i < len; i++) begin
      if (i < n) got = (k == 0) ? log_c[i] : log_l[i];
      else       got = 8'hEE;
      checkOutput({name, "_byte"}, k, 32'(got), 32'(exp[i]));
    end
  endtask

  // Request one message and act as the UART: done tick 4 cycles after each
  // start strobe. mode 1 adds sends and time changes mid-message; mode 2 adds
  // done ticks in IDLE and START. stop_at > 0 returns after that many strobes.
  task automatic applyStimulus(input logic [19:0] bcd, input int mode, input int stop_at);
    int starts;
    int cd;
    int cyc;
    bit finished;
    starts   = 0;
    cd       = -1;
    cyc      = 0;
    finished = 1'b0;
    @(negedge clk);
    time_bcd     = bcd;
    send         = 1'b1;
    tx_done_tick = (mode == 2);
    @(negedge clk);
    while (!finished && cyc < 400) begin
      send         = 1'b0;
      tx_done_tick = 1'b0;
      if (start_n_c === 1'b0) begin
        starts++;
        cd = 3;
        if (mode == 2) tx_done_tick = 1'b1;
        if (mode == 1 && starts == 3) begin
          send     = 1'b1;
          time_bcd = 20'h98765;
        end
        if (stop_at > 0 && starts == stop_at) finished = 1'b1;
      end else if (cd == 0) begin
        tx_done_tick = 1'b1;
        cd = -1;
        if (mode == 1 && starts < 9) send = 1'b1;
      end else if (cd > 0) begin
        cd--;
      end else if (!busy_c && !busy_l && starts > 0) begin
        finished = 1'b1;
      end
      if (!finished) begin
        @(negedge clk);
        cyc++;
      end
    end
    checkOutput("serve_timeout", 0, 32'(cyc < 400), 32'd1);
    if (stop_at == 0) begin
      send         = 1'b0;
      tx_done_tick = 1'b0;
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by a randomized run
  initial begin
    rst_n        = 1'b0;
    send         = 1'b0;
    tx_done_tick = 1'b0;
    time_bcd     = 20'h0;
    clear_logs();
    repeat (3) @(negedge clk);
    #2;
    checkOutput("reset_tx_start_n", 0, 32'(start_n_c), 32'd1);
    checkOutput("reset_tx_data",    0, 32'(data_c),    32'h00);
    checkOutput("reset_busy",       0, 32'(busy_c),    32'd0);
    checkOutput("reset_msg_done",   0, 32'(done_c),    32'd0);
    checkOutput("reset_tx_data",    1, 32'(data_l),    32'h00);
    checkOutput("reset_busy",       1, 32'(busy_l),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] message 12345");
    clear_logs();
    applyStimulus(20'h12345, 0, 0);
    checkLog("msg_12345", 0, exp_a_c, 9);
    checkLog("msg_12345", 1, exp_a_l, 8);
    checkOutput("done_count_12345", 0, 32'(done_cnt[0]), 32'd1);
    checkOutput("done_count_12345", 1, 32'(done_cnt[1]), 32'd1);

    $display("[TB] message 00000 with done ticks in IDLE and START");
    clear_logs();
    applyStimulus(20'h00000, 2, 0);
    checkLog("msg_00000", 0, exp_z_c, 9);
    checkLog("msg_00000", 1, exp_z_l, 8);
    checkOutput("done_count_00000", 0, 32'(done_cnt[0]), 32'd1);
    checkOutput("done_count_00000", 1, 32'(done_cnt[1]), 32'd1);

    $display("[TB] message 12A45");
    clear_logs();
    applyStimulus(20'h12A45, 0, 0);
    checkLog("msg_12a45", 0, exp_q_c, 9);
    checkLog("msg_12a45", 1, exp_q_l, 8);

    $display("[TB] message 24680 with sends and time changes mid-message");
    clear_logs();
    applyStimulus(20'h24680, 1, 0);
    checkLog("msg_24680", 0, exp_d_c, 9);
    checkLog("msg_24680", 1, exp_d_l, 8);
    checkOutput("done_count_24680", 0, 32'(done_cnt[0]), 32'd1);
    checkOutput("done_count_24680", 1, 32'(done_cnt[1]), 32'd1);

    $display("[TB] reset while waiting on byte 4");
    clear_logs();
    applyStimulus(20'h13579, 0, 5);
    @(negedge clk);
    send         = 1'b0;
    tx_done_tick = 1'b0;
    rst_n        = 1'b0;
    #1;
    checkOutput("abort_tx_start_n", 0, 32'(start_n_c), 32'd1);
    checkOutput("abort_busy",       0, 32'(busy_c),    32'd0);
    checkOutput("abort_tx_start_n", 1, 32'(start_n_l), 32'd1);
    checkOutput("abort_busy",       1, 32'(busy_l),    32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_logs();
    applyStimulus(20'h54321, 0, 0);
    checkLog("after_reset", 0, exp_r_c, 9);
    checkLog("after_reset", 1, exp_r_l, 8);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst_n        = ($urandom_range(0, 599) != 0);
      send         = ($urandom_range(0, 15) == 0);
      tx_done_tick = ($urandom_range(0, 3) == 0);
      time_bcd     = 20'($urandom());
    end
    @(negedge clk);
    rst_n        = 1'b1;
    send         = 1'b0;
    tx_done_tick = 1'b0;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stopwatch_msg_tx.md
STOPWATCH_MSG_TX -- requirements
Module: stopwatch_msg_tx

Interface
REQ-001 SHALL have parameter: CRLF, 1, 1 = terminate message with CR LF (9 bytes); 0 = LF only (8 bytes).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: send  input  1  single-cycle request to transmit the current time.
REQ-005 SHALL have port: time_bcd  input  20  BCD digits: [19:16] min tens, [15:12] min ones, [11:8] sec tens, [7:4] sec ones, [3:0] tenths.
REQ-006 SHALL have port: tx_done_tick  input  1  one-cycle pulse from the UART transmitter when a byte's stop bit completes.
REQ-007 SHALL have port: tx_start_n  output  1  active-low start strobe to the UART transmitter.
REQ-008 SHALL have port: tx_data  output  8  byte presented to the UART transmitter.
REQ-009 SHALL have port: busy  output  1  high while a message is in progress.
REQ-010 SHALL have port: msg_done  output  1  one-cycle pulse after the last byte of a message completes.

Function
REQ-011 SHALL emit the message "M M : S S . T" followed by the terminator: bytes digit, digit, 0x3A, digit, digit, 0x2E, digit, then 0x0D 0x0A (CRLF=1) or 0x0A (CRLF=0).
REQ-012 SHALL map BCD digit d in 0..9 to 0x30+d, and any digit 10..15 to 0x3F ('?').
REQ-013 SHALL snapshot time_bcd into an internal register on the clock edge where send=1 is accepted; later changes to time_bcd SHALL NOT affect the message in progress.
REQ-014 SHALL implement a state machine with states IDLE, START, WAIT.
REQ-015 IDLE: busy=0, tx_start_n=1; send=1 -> capture snapshot, byte index=0, go to START.
REQ-016 START: tx_start_n=0 for exactly one cycle, tx_data=byte[index], busy=1; unconditionally go to WAIT.
REQ-017 WAIT: tx_start_n=1, tx_data held stable, busy=1; on tx_done_tick: if index=last, go to IDLE; else index+1 and go to START.
REQ-018 SHALL assert msg_done for exactly one cycle, namely the cycle after the final tx_done_tick (first cycle back in IDLE).
REQ-019 Latency: accepted send at edge N -> tx_start_n low during cycle N+1; each subsequent byte's tx_start_n pulse follows its predecessor's tx_done_tick by exactly one cycle.
REQ-020 SHALL ignore send while busy=1, including send coincident with the final tx_done_tick; requests SHALL NOT be queued.
REQ-021 SHALL ignore tx_done_tick in IDLE and START.
REQ-022 tx_start_n, tx_data, busy and msg_done SHALL be driven from registers (no combinational path from inputs).
REQ-023 Byte index SHALL be 4 bits wide; last index = 8 (CRLF=1) or 7 (CRLF=0); index SHALL never exceed last.

Reset
REQ-024 Reset SHALL force state=IDLE, index=0, snapshot=0, tx_start_n=1, tx_data=0x00, busy=0, msg_done=0.
REQ-025 Reset during START or WAIT SHALL abort the message with no further tx_start_n pulse; the next accepted send SHALL restart at byte 0.

Structure
REQ-026 Package stopwatch_uart_pkg SHALL hold ASCII constants (0x30, 0x3A, 0x2E, 0x0D, 0x0A, 0x3F), the state encoding and the message-length constants.
REQ-027 SHALL instantiate one combinational sub-module bcd_to_ascii (4-bit BCD in, 8-bit ASCII out, per REQ-012) for byte generation.

Verification
REQ-028 time_bcd=0x12345, CRLF=1, send -> tx_data 0x31,0x32,0x3A,0x33,0x34,0x2E,0x35,0x0D,0x0A, one tx_start_n pulse each, single msg_done after 9th tx_done_tick.
REQ-029 CRLF=0, time_bcd=0x00000 -> 8 bytes 0x30,0x30,0x3A,0x30,0x30,0x2E,0x30,0x0A.
REQ-030 time_bcd=0x12A45 -> 4th byte 0x3F; all others per REQ-012.
REQ-031 send pulses and time_bcd changes during byte 3 -> no extra message; bytes match the original snapshot; busy stays high until the message ends.
REQ-032 rst_n low during WAIT of byte 4 -> tx_start_n=1, busy=0 immediately; next send emits byte 0 first.
REQ-033 tx_done_tick pulsed in IDLE and in START -> no index advance, no msg_done.
